or_accum16: RTL

OR_ACCUM16 -- requirements
Module: or_accum16

---
 rtl/or_accum16_if.sv | 31 +++
 rtl/or_accum16.sv | 77 +++++++
 2 files changed

// File: rtl/or_accum16_if.sv
// Handshake bundle between the upstream OR stage, the frame accumulator and
// the downstream consumer of completed frame results.
interface or_accum16_if;
  logic [15:0] inA;
  logic        inValid;
  logic        inReady;
  logic [15:0] out;
  logic        outValid;
  logic        outReady;
  logic [3:0]  count;

  modport master (
    output inA,
    output inValid,
    input  inReady,
    input  out,
    input  outValid,
    output outReady,
    input  count
  );

  modport slave (
    input  inA,
    input  inValid,
    output inReady,
    output out,
    output outValid,
    input  outReady,
    output count
  );
endinterface

// File: rtl/or_accum16.sv
// Frame OR accumulator: ORs FRAME_LEN accepted 16-bit words together, then
// holds the result until the downstream stage takes it.
module or_accum16 #(
  parameter int FRAME_LEN = 4
) (
  input  logic         clk,
  input  logic         reset,
  or_accum16_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [3:0] LP_LEN = 4'(FRAME_LEN);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_acc;
  logic [15:0] w_acc_next;
  logic [3:0]  r_count;
  logic [3:0]  w_count_next;
  logic [3:0]  w_count_inc;

  assign w_count_inc = r_count + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= 16'h0000;
      r_count <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_count_next = r_count;
    case (r_state)
      IDLE: begin
        // First word replaces the accumulator so nothing stale leaks in.
        if (bus.inValid) begin
          w_acc_next   = bus.inA;
          w_count_next = 4'd1;
          w_state_next = (LP_LEN == 4'd1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (bus.inValid) begin
          w_acc_next   = r_acc | bus.inA;
          w_count_next = w_count_inc;
          w_state_next = (w_count_inc == LP_LEN) ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (bus.outReady) begin
          w_acc_next   = 16'h0000;
          w_count_next = 4'd0;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_acc_next   = 16'h0000;
        w_count_next = 4'd0;
      end
    endcase
  end

  assign bus.inReady  = (r_state != HOLD);
  assign bus.outValid = (r_state == HOLD);
  assign bus.out      = r_acc;
  assign bus.count    = r_count;

endmodule
